// File: rtl/mainmem_backdoor_pkg.sv
// Shared types for the backdoor main-memory port: sequencer states, the queued
// request record and the byte-mask width of the scratchpad data lane.
package mainmem_backdoor_pkg;

  localparam int BD_ADDR_W = 32;
  localparam int BD_DATA_W = 64;
  localparam int MASK_W    = BD_DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    ISSUE,
    RD_WAIT,
    RESP
  } bd_state_e;

  typedef struct packed {
    logic                 write;
    logic [BD_ADDR_W-1:0] addr;
    logic [BD_DATA_W-1:0] wdata;
  } bd_req_t;

endpackage

// File: rtl/mainmem_backdoor_port_fifo.sv
// Generic synchronous FIFO used as the backdoor request queue. The head entry is
// presented combinationally on rdata; count has one extra bit so a full queue is
// distinguishable from an empty one when the pointers coincide.
module backdoor_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = store[rd_ptr];

  // Entry storage: payload only, never cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mainmem_backdoor_port.sv
// Backdoor main-memory port: queues 64-bit read/write commands from the system
// driver and sequences them one at a time onto the scratchpad wrapper port once
// the memory is out of reset and ownership is granted. Reads return through a
// registered response that is held until accepted.
// Optional build macro BACKDOOR_STATS_EN adds saturating write/read completion
// counters on wr_cnt/rd_cnt; without it both outputs are constant zero.
module mainmem_backdoor_port
  import mainmem_backdoor_pkg::*;
#(
  parameter int ADDR_W     = BD_ADDR_W,
  parameter int DATA_W     = BD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic                mem_rst,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_mask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [31:0]         wr_cnt,
  output logic [31:0]         rd_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bd_req_t          push_req;
  bd_req_t          head_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;
  bd_state_e        state;
  logic [2:0]       lat_cnt;

  assign push_req.write = req_write;
  assign push_req.addr  = req_addr;
  assign push_req.wdata = req_wdata;

  assign push = req_valid && req_ready && !fifo_full;
  assign pop  = (state == ISSUE);
  assign busy = !fifo_empty || (state != IDLE);

  backdoor_req_fifo #(
    .WIDTH ($bits(bd_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_req),
    .pop   (pop),
    .rdata (head_req),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy after this cycle's push/pop, used to register ready.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - CNT_W'(1);
    end
  end

  // Ready is registered, so a pop in the same cycle as a full queue cannot admit a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b0;
    end else begin
      req_ready <= (count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // Sequencer: every memory-side and response output is a registered value set on the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_mask  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !mem_rst) begin
            state    <= ARB;
            mem_req  <= 1'b1;
            mem_addr <= head_req.addr;
          end
        end
        ARB: begin
          if (mem_rst) begin
            // Memory went back into reset: release the port, keep the entry queued.
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end else if (mem_gnt) begin
            state     <= ISSUE;
            mem_mask  <= '1;
            mem_write <= head_req.write;
            mem_wdata <= head_req.write ? head_req.wdata : '0;
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
          mem_mask  <= '0;
          mem_wdata <= '0;
          if (head_req.write) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
          end else begin
            state   <= RD_WAIT;
            lat_cnt <= 3'(RD_LATENCY);
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 3'd1) begin
            state     <= RESP;
            rsp_rdata <= mem_rdata;
            rsp_valid <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            lat_cnt   <= '0;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef BACKDOOR_STATS_EN
  logic [31:0] wr_cnt_q;
  logic [31:0] rd_cnt_q;

  // Completion counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state == ISSUE && head_req.write && wr_cnt_q != 32'hFFFF_FFFF) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      if (state == RESP && rsp_ready && rd_cnt_q != 32'hFFFF_FFFF) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign wr_cnt = wr_cnt_q;
  assign rd_cnt = rd_cnt_q;
`else
  assign wr_cnt = 32'd0;
  assign rd_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mainmem_backdoor_port.sv
// Self-checking bench for mainmem_backdoor_port: a reset check, hand-written
// sequences for memory reset hold, write/read latency, a full queue, a stalled
// response and reset mid-read, a table of write/read-back vectors, and the
// optional completion counters.
module tb_mainmem_backdoor_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        mem_rst;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_write;
  logic [7:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        busy;
  logic [31:0] wr_cnt;
  logic [31:0] rd_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mainmem_backdoor_port dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_rst   (mem_rst),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_write (mem_write),
    .mem_mask  (mem_mask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
  );

  // Scratchpad model with one-cycle registered read data.
  logic [63:0] mm [128];

  function automatic logic [6:0] mm_idx(input logic [31:0] a);
    return {a[15:12], a[5:3]};
  endfunction

  always @(posedge clk) begin
    if (mem_mask != 8'h00) begin
      if (mem_write) mm[mm_idx(mem_addr)] <= mem_wdata;
      else           mem_rdata <= mm[mm_idx(mem_addr)];
    end
  end

  // Write strobe log.
  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } wr_rec_t;

  wr_rec_t wr_log[$];
  int      wr_memrst_viol = 0;

  always @(posedge clk) begin
    if (mem_write) begin
      wr_log.push_back('{addr: mem_addr, data: mem_wdata, mask: mem_mask});
      if (mem_rst) wr_memrst_viol++;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [63:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int k = 0; k < 60; k++) begin
      if (req_ready) begin
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    timeout_fail("push");
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      if (!busy) return;
      @(negedge clk);
    end
    timeout_fail(name);
  endtask

  task automatic wait_issue(input string name);
    for (int k = 0; k < 40; k++) begin
      if (mem_mask != 8'h00) return;
      @(negedge clk);
    end
    timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) return;
      @(negedge clk);
    end
    timeout_fail(name);
  endtask

  task automatic wait_rsp(input logic [63:0] exp, input string name);
    rsp_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (rsp_valid) begin
        check(name, rsp_rdata, exp);
        @(negedge clk);
        rsp_ready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    timeout_fail(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    vecs[0] = '{wr: 1'b1, addr: 32'h0000_3000, data: 64'h0123_4567_89AB_CDEF};
    vecs[1] = '{wr: 1'b1, addr: 32'h0000_3008, data: 64'hFFFF_0000_FFFF_0000};
    vecs[2] = '{wr: 1'b0, addr: 32'h0000_3000, data: 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{wr: 1'b0, addr: 32'h0000_3008, data: 64'hFFFF_0000_FFFF_0000};
    vecs[4] = '{wr: 1'b1, addr: 32'h0000_3000, data: 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[5] = '{wr: 1'b0, addr: 32'h0000_3000, data: 64'hA5A5_5A5A_0F0F_F0F0};
    vecs[6] = '{wr: 1'b0, addr: 32'h0000_1000, data: 64'hDEAD_BEEF_CAFE_F00D};
    vecs[7] = '{wr: 1'b0, addr: 32'h0000_2000, data: 64'h1122_3344_5566_7788};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    mem_rst   = 1'b0;
    mem_gnt   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mem_mask", 64'(mem_mask), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_rst", 64'(req_ready), 64'd1);

    // Memory held in reset: request waits, then issues exactly once
    mem_rst = 1'b1;
    repeat (10) @(negedge clk);
    push(1'b1, 32'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D);
    repeat (6) @(negedge clk);
    check("memrst_no_strobe", 64'(wr_log.size()), 64'd0);
    check("memrst_no_req", 64'(mem_req), 64'd0);
    check("memrst_busy", 64'(busy), 64'd1);
    mem_rst = 1'b0;
    wait_idle("memrst_idle");
    check("memrst_one_strobe", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() >= 1) begin
      check("memrst_addr", 64'(wr_log[0].addr), 64'h1000);
      check("memrst_mask", 64'(wr_log[0].mask), 64'hFF);
      check("memrst_data", wr_log[0].data, 64'hDEAD_BEEF_CAFE_F00D);
    end
    check("memrst_strobe_in_rst", 64'(wr_memrst_viol), 64'd0);

    // Write latency: accepted at t, strobe at t+3
    push(1'b1, 32'h0000_2000, 64'h1122_3344_5566_7788);
    check("wr_lat_t1", 64'(mem_write), 64'd0);
    @(negedge clk);
    check("wr_lat_t2_req", 64'(mem_req), 64'd1);
    check("wr_lat_t2_wr", 64'(mem_write), 64'd0);
    @(negedge clk);
    check("wr_lat_t3_wr", 64'(mem_write), 64'd1);
    check("wr_lat_t3_addr", 64'(mem_addr), 64'h2000);
    wait_idle("wr_lat_idle");

    // Read latency: rsp_valid two cycles after ISSUE
    push(1'b0, 32'h0000_2000, 64'd0);
    wait_issue("rd_lat_issue");
    check("rd_lat_issue_nowrite", 64'(mem_write), 64'd0);
    @(negedge clk);
    check("rd_lat_i1_valid", 64'(rsp_valid), 64'd0);
    check("rd_lat_i1_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    check("rd_lat_i2_valid", 64'(rsp_valid), 64'd1);
    check("rd_lat_i2_data", rsp_rdata, 64'h1122_3344_5566_7788);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rd_lat_valid_clear", 64'(rsp_valid), 64'd0);
    wait_idle("rd_lat_idle");

    // Table of write / read-back vectors
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) begin
        n = wr_log.size();
        push(1'b1, vecs[i].addr, vecs[i].data);
        wait_idle($sformatf("tbl%0d_idle", i));
        check($sformatf("tbl%0d_wr_count", i), 64'(wr_log.size()), 64'(n + 1));
        check($sformatf("tbl%0d_wr_addr", i), 64'(wr_log[$].addr), 64'(vecs[i].addr));
        check($sformatf("tbl%0d_wr_data", i), wr_log[$].data, vecs[i].data);
      end else begin
        push(1'b0, vecs[i].addr, 64'd0);
        wait_rsp(vecs[i].data, $sformatf("tbl%0d_rd_data", i));
        wait_idle($sformatf("tbl%0d_idle", i));
      end
    end

    // Full queue with grant withheld
    mem_gnt = 1'b0;
    n = wr_log.size();
    for (int i = 0; i < 4; i++) begin
      push(1'b1, 32'h0000_5000 + 32'(i * 8), {32'hF0F0_0000 + 32'(i), 32'h1234_0000});
    end
    check("full_req_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0000_6000;
    req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    bad = 0;
    repeat (4) begin
      if (req_ready) bad++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("full_5th_refused", 64'(bad), 64'd0);
    check("full_no_issue", 64'(wr_log.size()), 64'(n));
    mem_gnt = 1'b1;
    wait_idle("full_idle");
    check("full_four_strobes", 64'(wr_log.size()), 64'(n + 4));
    if (wr_log.size() >= n + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("full_order%0d_addr", i), 64'(wr_log[n + i].addr), 64'(32'h0000_5000 + 32'(i * 8)));
        check($sformatf("full_order%0d_data", i), wr_log[n + i].data,
              {32'hF0F0_0000 + 32'(i), 32'h1234_0000});
      end
    end
    check("full_ready_back", 64'(req_ready), 64'd1);

    // Stalled response holds and blocks further issue
    push(1'b0, 32'h0000_3008, 64'd0);
    push(1'b1, 32'h0000_4000, 64'h0BAD_F00D_0000_0001);
    n = wr_log.size();
    wait_valid("stall_valid");
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== 64'hFFFF_0000_FFFF_0000 || mem_req) bad++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    check("stall_no_issue", 64'(wr_log.size()), 64'(n));
    wait_rsp(64'hFFFF_0000_FFFF_0000, "stall_release_data");
    wait_idle("stall_idle");
    check("stall_then_write", 64'(wr_log.size()), 64'(n + 1));
    check("stall_then_write_addr", 64'(wr_log[$].addr), 64'h4000);

    // Reset during RD_WAIT drops the read
    push(1'b0, 32'h0000_3000, 64'd0);
    wait_issue("rdwait_issue");
    @(negedge clk);
    check("rdwait_req", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rdwait_rst_valid", 64'(rsp_valid), 64'd0);
    check("rdwait_rst_req", 64'(mem_req), 64'd0);
    check("rdwait_rst_busy", 64'(busy), 64'd0);
    check("rdwait_rst_ready", 64'(req_ready), 64'd0);
    check("rdwait_rst_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    check("rdwait_no_response", 64'(bad), 64'd0);

    // Completion counters
    push(1'b1, 32'h0000_7000, 64'h7000_0000_0000_0001);
    push(1'b1, 32'h0000_7008, 64'h7008_0000_0000_0002);
    push(1'b1, 32'h0000_7010, 64'h7010_0000_0000_0003);
    wait_idle("stats_wr_idle");
    push(1'b0, 32'h0000_7008, 64'd0);
    wait_rsp(64'h7008_0000_0000_0002, "stats_rd0_data");
    push(1'b0, 32'h0000_7010, 64'd0);
    wait_rsp(64'h7010_0000_0000_0003, "stats_rd1_data");
    wait_idle("stats_rd_idle");
`ifdef BACKDOOR_STATS_EN
    check("stats_wr_cnt", 64'(wr_cnt), 64'd3);
    check("stats_rd_cnt", 64'(rd_cnt), 64'd2);
`else
    check("stats_wr_cnt", 64'(wr_cnt), 64'd0);
    check("stats_rd_cnt", 64'(rd_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
